// File: rtl/host_seq.sv
// host_seq: host-side sequencer that clears core data memory, loads a
// byte block, pulses Start, waits for a qualified Ack, then streams
// the result bytes out over a valid/ready port.
// Ports:
//   Clk, Reset (sync, active-high)
//   Go            start request, taken only in IDLE
//   InValid/InData/InReady     load byte stream
//   MemWrEn/MemAddr/MemWrData  data-memory write port
//   MemRdData     combinational read data at MemAddr
//   Start/Ack     core handshake
//   OutValid/OutData/OutReady  result byte stream
//   Busy          high outside IDLE
//   Err           sticky RUN-timeout abort flag
// Define HOST_SEQ_TIMEOUT_EN to add the RUN timeout (parameter TIMEOUT);
// without it RUN waits forever and Err is tied low.
module host_seq #(
  parameter int ADDR_W    = 8,
  parameter int LOAD_BASE = 128,
  parameter int LOAD_LEN  = 8,
  parameter int RES_BASE  = 5,
  parameter int RES_LEN   = 4,
`ifdef HOST_SEQ_TIMEOUT_EN
  parameter int TIMEOUT   = 4096,
`endif
  parameter int START_CYC = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Go,
  input  logic              InValid,
  input  logic [7:0]        InData,
  output logic              InReady,
  output logic              MemWrEn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        MemWrData,
  input  logic [7:0]        MemRdData,
  output logic              Start,
  input  logic              Ack,
  output logic              OutValid,
  output logic [7:0]        OutData,
  input  logic              OutReady,
  output logic              Busy,
  output logic              Err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_START,
    S_RUN,
    S_RD_ADDR,
    S_RD_OUT
  } state_t;

  // One shared counter; wide enough for 2**ADDR_W and START_CYC.
  localparam int SW = $clog2(START_CYC) + 1;
  localparam int CW = (ADDR_W + 1 > SW) ? ADDR_W + 1 : SW;

  localparam logic [CW-1:0] CLR_LAST = CW'((1 << ADDR_W) - 1);
  localparam logic [CW-1:0] LD_LAST  = CW'(LOAD_LEN - 1);
  localparam logic [CW-1:0] ST_LAST  = CW'(START_CYC - 1);
  localparam logic [CW-1:0] RS_LAST  = CW'(RES_LEN - 1);

  localparam logic [ADDR_W-1:0] LD_BASE = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] RS_BASE = ADDR_W'(RES_BASE);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] cnt_a;
  logic              armed;
  logic [7:0]        out_q;

  assign cnt_a = cnt[ADDR_W-1:0];

  assign InReady  = (state == S_LOAD);
  assign Start    = (state == S_START);
  assign OutValid = (state == S_RD_OUT);
  assign OutData  = out_q;
  assign Busy     = (state != S_IDLE);

  // Memory port is decoded from state so a load byte is written in the
  // same cycle it is accepted; addresses wrap modulo the memory depth.
  always_comb begin
    MemWrEn   = 1'b0;
    MemAddr   = '0;
    MemWrData = '0;
    case (state)
      S_CLEAR: begin
        MemWrEn = 1'b1;
        MemAddr = cnt_a;
      end
      S_LOAD: begin
        if (InValid) begin
          MemWrEn   = 1'b1;
          MemAddr   = LD_BASE + cnt_a;
          MemWrData = InData;
        end
      end
      S_RD_ADDR: MemAddr = RS_BASE + cnt_a;
      default: ;
    endcase
  end

`ifdef HOST_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TM_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmr;
  logic          err_q;

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      armed <= 1'b0;
      out_q <= '0;
`ifdef HOST_SEQ_TIMEOUT_EN
      tmr   <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (Go) begin
            state <= S_CLEAR;
            cnt   <= '0;
`ifdef HOST_SEQ_TIMEOUT_EN
            err_q <= 1'b0;
`endif
          end
        end
        S_CLEAR: begin
          if (cnt == CLR_LAST) begin
            state <= S_LOAD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LOAD: begin
          if (InValid) begin
            if (cnt == LD_LAST) begin
              state <= S_START;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_START: begin
          if (cnt == ST_LAST) begin
            state <= S_RUN;
            cnt   <= '0;
            armed <= 1'b0;
`ifdef HOST_SEQ_TIMEOUT_EN
            tmr   <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          // Ack counts only after a low sample in this RUN, so a level
          // left high by the previous run cannot end this one.
          if (!Ack) armed <= 1'b1;
          if (Ack && armed) begin
            state <= S_RD_ADDR;
            cnt   <= '0;
          end
`ifdef HOST_SEQ_TIMEOUT_EN
          else if (tmr == TM_LAST) begin
            state <= S_IDLE;
            err_q <= 1'b1;
          end else begin
            tmr <= tmr + 1'b1;
          end
`endif
        end
        S_RD_ADDR: begin
          out_q <= MemRdData;
          state <= S_RD_OUT;
        end
        S_RD_OUT: begin
          if (OutReady) begin
            if (cnt == RS_LAST) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_RD_ADDR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_seq.sv
// tb_host_seq: directed bench for host_seq with a byte memory and a
// scripted core; checks memory traffic, Start width and result stream.
module tb_host_seq;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Go = 1'b0;
  logic       InValid = 1'b0;
  logic [7:0] InData = 8'h00;
  logic       Ack = 1'b0;
  logic       OutReady = 1'b1;
  logic       InReady, MemWrEn, Start, OutValid, Busy, Err;
  logic [7:0] MemAddr, MemWrData, MemRdData, OutData;

  logic       w_go = 1'b0;
  logic       w_valid = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       w_ready, w_wen, w_start, w_ov, w_busy, w_err;
  logic [7:0] w_addr, w_wdata, w_od;

  logic [7:0] mem [256];
  logic       core_wr = 1'b0;
  logic       fill = 1'b0;

  int  n_chk = 0;
  int  n_err = 0;
  int  widx = 0;
  int  st_cnt = 0;
  bit  mon_en = 1'b0;
  bit  ov_seen = 1'b0;
  bit  hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;
  logic [7:0] out_q [$];

  logic [7:0] bytes [8] = '{8'h0d, 8'h10, 8'h13, 8'h14,
                            8'h2a, 8'h37, 8'h4e, 8'h72};
  logic [7:0] res [4] = '{8'hde, 8'had, 8'hbe, 8'hef};
  logic [7:0] wa [4] = '{8'd254, 8'd255, 8'd0, 8'd1};

  always #5 Clk = ~Clk;

  host_seq #(
    .ADDR_W(8)
`ifdef HOST_SEQ_TIMEOUT_EN
    , .TIMEOUT(100)
`endif
  ) dut (
    .Clk(Clk), .Reset(Reset), .Go(Go),
    .InValid(InValid), .InData(InData), .InReady(InReady),
    .MemWrEn(MemWrEn), .MemAddr(MemAddr), .MemWrData(MemWrData),
    .MemRdData(MemRdData), .Start(Start), .Ack(Ack),
    .OutValid(OutValid), .OutData(OutData), .OutReady(OutReady),
    .Busy(Busy), .Err(Err)
  );

  host_seq #(.LOAD_BASE(254), .LOAD_LEN(4)) u_wrap (
    .Clk(Clk), .Reset(Reset), .Go(w_go),
    .InValid(w_valid), .InData(w_data), .InReady(w_ready),
    .MemWrEn(w_wen), .MemAddr(w_addr), .MemWrData(w_wdata),
    .MemRdData(8'h00), .Start(w_start), .Ack(1'b0),
    .OutValid(w_ov), .OutData(w_od), .OutReady(1'b1),
    .Busy(w_busy), .Err(w_err)
  );

  assign MemRdData = mem[MemAddr];

  always @(posedge Clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hff;
    end else if (MemWrEn) begin
      mem[MemAddr] <= MemWrData;
    end
    if (core_wr) begin
      mem[5] <= 8'hde;
      mem[6] <= 8'had;
      mem[7] <= 8'hbe;
      mem[8] <= 8'hef;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (mon_en) begin
      if (MemWrEn) begin
        if (widx < 256) begin
          chk("clr_addr", 32'(MemAddr), widx);
          chk("clr_data", 32'(MemWrData), 0);
        end else if (widx < 264) begin
          chk("ld_addr", 32'(MemAddr), 128 + widx - 256);
          chk("ld_data", 32'(MemWrData), 32'(bytes[widx-256]));
        end else begin
          chk("extra_wr", 32'(MemAddr), 32'hffff);
        end
        widx++;
      end
      if (Start) st_cnt++;
      if (OutValid) ov_seen = 1'b1;
      if (OutValid && OutReady) out_q.push_back(OutData);
      if (hold_v) begin
        chk("ov_hold", 32'(OutValid), 1);
        chk("od_hold", 32'(OutData), 32'(hold_d));
      end
      hold_v = OutValid && !OutReady;
      hold_d = OutData;
    end
  end

  task automatic start_seq(input bit gap, input bit stale);
    int t;
    out_q.delete();
    widx = 0;
    st_cnt = 0;
    ov_seen = 1'b0;
    hold_v = 1'b0;
    fill = 1'b1;
    tick();
    fill = 1'b0;
    mon_en = 1'b1;
    Ack = stale;
    Go = 1'b1;
    tick();
    Go = 1'b0;
    chk("busy_go", 32'(Busy), 1);
    t = 0;
    while (!InReady && t < 400) begin
      tick();
      t++;
    end
    chk("clr_done", 32'(InReady), 1);
    chk("clr_cnt", widx, 256);
    for (int k = 0; k < 8; k++) begin
      if (gap) begin
        InValid = 1'b0;
        tick();
      end
      InValid = 1'b1;
      InData = bytes[k];
      tick();
    end
    InValid = 1'b0;
    chk("ld_cnt", widx, 264);
    chk("start_on", 32'(Start), 1);
    t = 0;
    while (Start && t < 10) begin
      tick();
      t++;
    end
    chk("start_cyc", st_cnt, 2);
  endtask

  task automatic run_seq(input bit gap, input bit stall, input bit stale);
    int t;
    OutReady = !stall;
    start_seq(gap, stale);
    Go = 1'b1;
    tick();
    Go = 1'b0;
    if (stale) begin
      repeat (4) tick();
      chk("stale_ov", 32'(OutValid), 0);
      Ack = 1'b0;
      core_wr = 1'b1;
      tick();
      core_wr = 1'b0;
      repeat (9) tick();
      chk("stale_wait", 32'(ov_seen), 0);
    end else begin
      core_wr = 1'b1;
      tick();
      core_wr = 1'b0;
      repeat (48) tick();
    end
    Ack = 1'b1;
    tick();
    chk("rd_lat0", 32'(OutValid), 0);
    tick();
    chk("rd_lat1", 32'(OutValid), 1);
    for (int b = 0; b < 4; b++) begin
      t = 0;
      while (!OutValid && t < 10) begin
        tick();
        t++;
      end
      if (stall) begin
        repeat (3) tick();
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
      end else begin
        tick();
      end
    end
    chk("done_idle", 32'(Busy), 0);
    chk("n_out", out_q.size(), 4);
    for (int b = 0; b < 4; b++)
      chk("out_byte", 32'(out_q[b]), 32'(res[b]));
    for (int k = 0; k < 8; k++)
      chk("mem_ld", 32'(mem[128+k]), 32'(bytes[k]));
    chk("mem_clr88", 32'(mem[136]), 0);
    chk("mem_clr0", 32'(mem[0]), 0);
    mon_en = 1'b0;
    OutReady = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) tick();
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_wen", 32'(MemWrEn), 0);
    chk("rst_addr", 32'(MemAddr), 0);
    chk("rst_start", 32'(Start), 0);
    chk("rst_ov", 32'(OutValid), 0);
    chk("rst_od", 32'(OutData), 0);
    chk("rst_err", 32'(Err), 0);
    Reset = 1'b0;
    InValid = 1'b1;
    tick();
    chk("idle_ready", 32'(InReady), 0);
    chk("idle_wen", 32'(MemWrEn), 0);
    InValid = 1'b0;

    run_seq(1'b0, 1'b0, 1'b0);
    run_seq(1'b1, 1'b1, 1'b0);
    run_seq(1'b0, 1'b0, 1'b1);

    Go = 1'b1;
    tick();
    Go = 1'b0;
    t = 0;
    while (!InReady && t < 400) begin
      tick();
      t++;
    end
    for (int k = 0; k < 3; k++) begin
      InValid = 1'b1;
      InData = bytes[k];
      tick();
    end
    Reset = 1'b1;
    tick();
    chk("mid_busy", 32'(Busy), 0);
    chk("mid_ready", 32'(InReady), 0);
    chk("mid_wen", 32'(MemWrEn), 0);
    chk("mid_addr", 32'(MemAddr), 0);
    chk("mid_wdata", 32'(MemWrData), 0);
    chk("mid_od", 32'(OutData), 0);
    Reset = 1'b0;
    InValid = 1'b0;
    Go = 1'b1;
    tick();
    Go = 1'b0;
    chk("re_wen", 32'(MemWrEn), 1);
    chk("re_addr0", 32'(MemAddr), 0);
    tick();
    chk("re_addr1", 32'(MemAddr), 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;

    w_go = 1'b1;
    tick();
    w_go = 1'b0;
    t = 0;
    while (!w_ready && t < 400) begin
      tick();
      t++;
    end
    for (int k = 0; k < 4; k++) begin
      w_valid = 1'b1;
      w_data = 8'h50 + 8'(k);
      @(negedge Clk);
      chk("wrap_wen", 32'(w_wen), 1);
      chk("wrap_addr", 32'(w_addr), 32'(wa[k]));
      chk("wrap_data", 32'(w_wdata), 32'h50 + k);
      tick();
    end
    w_valid = 1'b0;
    chk("wrap_start", 32'(w_start), 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;

`ifdef HOST_SEQ_TIMEOUT_EN
    OutReady = 1'b1;
    start_seq(1'b0, 1'b0);
    t = 0;
    while (Busy && t < 300) begin
      tick();
      t++;
    end
    chk("to_cycles", t, 100);
    chk("to_err", 32'(Err), 1);
    chk("to_noout", 32'(ov_seen), 0);
    mon_en = 1'b0;
    Go = 1'b1;
    tick();
    Go = 1'b0;
    chk("to_errclr", 32'(Err), 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
